stream_pattern_checker: RTL

Synthesizable receiving end for incrementing-pattern stream traffic. Consumes a valid/ready byte stream, for example from the dout side of stream_fifo_2clk. Compares every accepted word against an internally generated incrementing sequence and reports pass/fail, error count and first-error details. Provides on-chip FIFO and link checking without file-based sinks; optional periodic backpressure exercises upstream ready handling.

---
 rtl/stream_check_defs.sv | 21 ++
 rtl/stream_throttle.sv | 46 ++++
 rtl/stream_pattern_checker.sv | 138 +++++++++++++
 3 files changed

// File: rtl/stream_check_defs.sv
// Shared definitions for the stream checking blocks: FSM state encoding and
// a constant-evaluable ceil(log2) used to size counters and ports.
package stream_check_defs;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Smallest n such that 2**n >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/stream_throttle.sv
// Periodic stall generator. Counts the cycles of an active phase and flags
// the cycle, one cycle ahead, on which a registered ready must be held low.
// Period = 0 never stalls; Period = 1 would stall every cycle and is not a
// meaningful setting.
module stream_throttle
  import stream_check_defs::*;
#(
  parameter int Period = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_advance,
  output logic o_stallNext
);

  localparam int CntW = (Period >= 2) ? clog2(Period) : 1;
  localparam int LastVal = (Period > 0) ? (Period - 1) : 0;
  localparam logic [CntW-1:0] LastCnt = CntW'(LastVal);
  localparam logic Enabled = (Period != 0);

  logic [CntW-1:0] r_stallCnt;
  logic [CntW-1:0] w_cntNext;

  // Next counter value: restart on clear, otherwise step and wrap while active.
  always_comb begin
    w_cntNext = r_stallCnt;
    if (i_clear) begin
      w_cntNext = '0;
    end else if (i_advance) begin
      w_cntNext = (r_stallCnt == LastCnt) ? '0 : (r_stallCnt + 1'b1);
    end
  end

  // Cycle-position counter within the stall period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stallCnt <= '0;
    end else begin
      r_stallCnt <= w_cntNext;
    end
  end

  assign o_stallNext = Enabled && (w_cntNext == LastCnt);

endmodule

// File: rtl/stream_pattern_checker.sv
// Receive-side checker for an incrementing-pattern valid/ready stream.
// Every accepted word is compared with Seed + index (mod 2**Width); the block
// reports pass/fail, a saturating error count and the first bad word.
module stream_pattern_checker
  import stream_check_defs::*;
#(
  parameter int Width       = 8,
  parameter int NumWords    = 256,
  parameter int Seed        = 0,
  parameter int StallPeriod = 0,
  parameter int ErrCntBits  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              din_valid,
  output logic                              din_ready,
  input  logic [Width-1:0]                  din_data,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic [ErrCntBits-1:0]             err_count,
  output logic [clog2(NumWords+1)-1:0]      word_count,
  output logic [clog2(NumWords+1)-1:0]      first_err_index,
  output logic [Width-1:0]                  first_err_data
);

  localparam int CntW = clog2(NumWords + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(NumWords - 1);
  localparam logic [Width-1:0] SeedVal = Width'(Seed);

  state_t                r_state;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [ErrCntBits-1:0] r_errCount;
  logic [CntW-1:0]       r_wordCount;
  logic [CntW-1:0]       r_firstIdx;
  logic [Width-1:0]      r_firstData;
  logic [Width-1:0]      r_expected;

  logic w_inRun;
  logic w_startRun;
  logic w_xfer;
  logic w_lastXfer;
  logic w_mismatch;
  logic w_stallNext;

  assign w_inRun    = (r_state == S_RUN);
  assign w_startRun = start && !w_inRun;
  assign w_xfer     = din_valid && r_ready;
  assign w_lastXfer = w_xfer && (r_wordCount == LastIdx);
  assign w_mismatch = (din_data != r_expected);

  // Stall counter restarts on entry to RUN so every run sees the same ready pattern.
  stream_throttle #(
    .Period(StallPeriod)
  ) u_throttle (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_startRun),
    .i_advance  (w_inRun),
    .o_stallNext(w_stallNext)
  );

  // Run-control FSM with registered status outputs and the checking datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_errCount  <= '0;
      r_wordCount <= '0;
      r_firstIdx  <= '0;
      r_firstData <= '0;
      r_expected  <= SeedVal;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_ready <= 1'b0;
          if (start) begin
            r_state     <= S_RUN;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_errCount  <= '0;
            r_wordCount <= '0;
            r_firstIdx  <= '0;
            r_firstData <= '0;
            r_expected  <= SeedVal;
            r_ready     <= !w_stallNext;
          end
        end
        S_RUN: begin
          r_ready <= !w_stallNext;
          if (w_xfer) begin
            r_expected  <= r_expected + 1'b1;
            r_wordCount <= r_wordCount + 1'b1;
            if (w_mismatch) begin
              r_err <= 1'b1;
              if (r_errCount != '1) begin
                r_errCount <= r_errCount + 1'b1;
              end
              if (r_errCount == '0) begin
                r_firstIdx  <= r_wordCount;
                r_firstData <= din_data;
              end
            end
            if (w_lastXfer) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_ready <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign din_ready       = r_ready;
  assign busy            = r_busy;
  assign done            = r_done;
  assign err             = r_err;
  assign err_count       = r_errCount;
  assign word_count      = r_wordCount;
  assign first_err_index = r_firstIdx;
  assign first_err_data  = r_firstData;

endmodule
